// File: rtl/ntt_pkg.sv
// Shared NTT constants, sequencer state encoding and twiddle index helper.
// Pure definitions: no latency, no flow control.
// Imported by the stage sequencer and the butterfly datapath.
package ntt_pkg;

  localparam int RING_SIZE = 1024;
  localparam int DATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

  // Twiddle group base for this stage plus the top 'stage' bits of k.
  function automatic int unsigned tw_index(input int unsigned stage,
                                           input int unsigned k,
                                           input int unsigned addr_w);
    return (32'd1 << stage) | (k >> (addr_w - stage));
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Resettable fixed-depth shift register re-timing read-side controls to write-side.
// Latency: exactly DEPTH cycles, no bubbles, no reordering.
// No backpressure: advances every cycle.
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences in-place NTT butterfly stages: reads, twiddle/select generation, write-back.
// Latency: first read 1 cycle after start; done at 1+NSTAGE*(HALF+LAT) cycles.
// No backpressure: one butterfly per cycle; drain gap between stages avoids RAW hazards.
module ntt_stage_sequencer #(
  parameter int RING_SIZE  = ntt_pkg::RING_SIZE,
  parameter int PE_LATENCY = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             rd_en,
  output logic [$clog2(RING_SIZE/2)-1:0]   rd_addr,
  output logic [$clog2(RING_SIZE)-1:0]     twiddle_addr,
  output logic                             sel_a,
  output logic                             sel_b,
  output logic                             wr_en,
  output logic [$clog2(RING_SIZE/2)-1:0]   wr_addr,
  output logic [$clog2(RING_SIZE)-1:0]     stage,
  output logic                             last_stage,
  output logic                             busy,
  output logic                             done
);

  import ntt_pkg::*;

  localparam int HALF    = RING_SIZE / 2;
  localparam int ADDR_W  = $clog2(HALF);
  localparam int TW_W    = $clog2(RING_SIZE);
  localparam int NSTAGE  = $clog2(RING_SIZE);
  localparam int LAT     = PE_LATENCY + 1;
  localparam int DCNT_W  = $clog2(LAT);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(HALF - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(LAT - 1);
  localparam logic [TW_W-1:0]   S_LAST = TW_W'(NSTAGE - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [TW_W-1:0]   stg, stg_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      stg   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      stg   <= stg_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    stg_nxt   = stg;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
          k_nxt     = '0;
          stg_nxt   = '0;
        end
      end
      READ: begin
        // k is exactly ADDR_W bits, so HALF-1 wraps to 0 for the next stage.
        k_nxt = k + 1'b1;
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        dcnt_nxt = dcnt + 1'b1;
        if (dcnt == D_LAST) begin
          if (stg == S_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
            stg_nxt   = stg + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic              reading;
  logic [ADDR_W-1:0] k_shr;
  logic [TW_W-1:0]   tw_d;
  logic              sel_d;

  always_comb begin
    reading = (state == READ);
    // Operand-pair select is the k bit just below the twiddle group bits.
    k_shr   = k >> (ADDR_W'(ADDR_W - 1) - stg[ADDR_W-1:0]);
    sel_d   = reading && (stg != S_LAST) && k_shr[0];
    tw_d    = '0;
    if (reading) tw_d = TW_W'(tw_index(32'(stg), 32'(k), ADDR_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      twiddle_addr <= '0;
      sel_a        <= 1'b0;
      stage        <= '0;
      last_stage   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rd_en        <= reading;
      rd_addr      <= reading ? k : '0;
      twiddle_addr <= tw_d;
      sel_a        <= sel_d;
      stage        <= stg;
      last_stage   <= (state == READ || state == DRAIN) && (stg == S_LAST);
      busy         <= (state == READ || state == DRAIN);
      done         <= (state == DONE);
    end
  end

  ntt_delay_line #(
    .WIDTH (1 + ADDR_W),
    .DEPTH (LAT)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (reset),
    .din  ({rd_en, rd_addr}),
    .dout ({wr_en, wr_addr})
  );

  // The add/sub select is needed one cycle before write-back.
  ntt_delay_line #(
    .WIDTH (1),
    .DEPTH (LAT - 1)
  ) u_sel_delay (
    .clk  (clk),
    .rst  (reset),
    .din  (sel_a),
    .dout (sel_b)
  );

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: cycle table for N=8, write scoreboard, N=1024 run.
module tb_ntt_stage_sequencer;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start_big;

  always #5 clk = ~clk;

  logic       rd_en, sel_a, sel_b, wr_en, last_stage, busy, done;
  logic [1:0] rd_addr, wr_addr;
  logic [2:0] twiddle_addr, stage;

  ntt_stage_sequencer #(.RING_SIZE(8), .PE_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .twiddle_addr(twiddle_addr),
    .sel_a(sel_a), .sel_b(sel_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .stage(stage), .last_stage(last_stage), .busy(busy), .done(done)
  );

  logic       b_rd_en, b_sel_a, b_sel_b, b_wr_en, b_last_stage, b_busy, b_done;
  logic [8:0] b_rd_addr, b_wr_addr;
  logic [9:0] b_twiddle_addr, b_stage;

  ntt_stage_sequencer #(.RING_SIZE(1024), .PE_LATENCY(4)) dut_big (
    .clk(clk), .reset(reset), .start(start_big),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .twiddle_addr(b_twiddle_addr),
    .sel_a(b_sel_a), .sel_b(b_sel_b), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .stage(b_stage), .last_stage(b_last_stage), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [2:0] tw;
    logic       sel_a;
    logic       sel_b;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] stage;
    logic       last_stage;
    logic       busy;
    logic       done;
  } row_t;

  typedef struct {
    logic [1:0] addr;
    int         due;
  } wr_exp_t;

  int checks = 0;
  int failures = 0;

  int tw_tab[12]  = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  int sel_tab[12] = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0};

  row_t    tbl[30];
  wr_exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected outputs c cycles after the start edge: 9 cycles per stage, 4 reads then 5 drain.
  function automatic row_t exp_row(input int c);
    row_t r;
    int s, p, w, b;
    r = '0;
    if (c >= 1 && c <= 27) begin
      s = (c - 1) / 9;
      p = (c - 1) % 9;
      r.busy       = 1'b1;
      r.stage      = 3'(s);
      r.last_stage = (s == 2);
      if (p < 4) begin
        r.rd_en   = 1'b1;
        r.rd_addr = 2'(p);
        r.tw      = 3'(tw_tab[s*4+p]);
        r.sel_a   = (sel_tab[s*4+p] != 0);
      end
    end
    if (c >= 28) r.stage = 3'd2;
    r.done = (c == 28);
    w = c - LAT;
    if (w >= 1 && w <= 27 && ((w - 1) % 9) < 4) begin
      r.wr_en   = 1'b1;
      r.wr_addr = 2'((w - 1) % 9);
    end
    b = c - (LAT - 1);
    if (b >= 1 && b <= 27 && ((b - 1) % 9) < 4)
      r.sel_b = (sel_tab[((b - 1) / 9) * 4 + (b - 1) % 9] != 0);
    return r;
  endfunction

  function automatic row_t cur();
    row_t r;
    r.rd_en = rd_en; r.rd_addr = rd_addr; r.tw = twiddle_addr;
    r.sel_a = sel_a; r.sel_b = sel_b; r.wr_en = wr_en; r.wr_addr = wr_addr;
    r.stage = stage; r.last_stage = last_stage; r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", 32'(cur()), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pulses start, then compares cycles 0..29 against the table and scoreboards writes.
  task automatic run_trace(input string tag, input bit restarts);
    int writes, dones;
    wr_exp_t e;
    writes = 0;
    dones  = 0;
    sb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 29; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      check($sformatf("%s_row_c%0d", tag, c), 32'(cur()), 32'(tbl[c]));
      if (done) dones++;
      if (rd_en) sb.push_back('{addr: rd_addr, due: c + LAT});
      if (wr_en) begin
        writes++;
        if (sb.size() == 0) begin
          check($sformatf("%s_sb_underflow_c%0d", tag, c), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s_sb_wr_addr_c%0d", tag, c), 32'(wr_addr), 32'(e.addr));
          check($sformatf("%s_sb_wr_cycle", tag), 32'(c), 32'(e.due));
        end
      end
      if (restarts && (c + 1 == 3 || c + 1 == 15)) start = 1'b1;
    end
    check($sformatf("%s_write_count", tag), 32'(writes), 32'd12);
    check($sformatf("%s_sb_empty", tag), 32'(sb.size()), 32'd0);
    check($sformatf("%s_done_count", tag), 32'(dones), 32'd1);
  endtask

  initial begin
    int cyc, reads, writes, twz;
    bit seen;

    for (int c = 0; c < 30; c++) tbl[c] = exp_row(c);

    reset     = 1'b1;
    start     = 1'b0;
    start_big = 1'b0;
    #1;
    check("async_reset_zero", 32'(cur()), 32'd0);

    // Basic full run, then start re-pulsed mid-run.
    do_reset();
    run_trace("basic", 1'b0);
    do_reset();
    run_trace("restart_ignored", 1'b1);

    // Reset at cycle 12, with a simultaneous start that must lose.
    do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("pre_reset_row_c%0d", c), 32'(cur()), 32'(tbl[c]));
    end
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("mid_reset_immediate", 32'(cur()), 32'd0);
    @(posedge clk); #1;
    check("mid_reset_with_start", 32'(cur()), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_idle_%0d", i), 32'(cur()), 32'd0);
    end
    run_trace("after_reset", 1'b0);

    // Full-size ring.
    do_reset();
    start_big = 1'b1;
    @(posedge clk); #1;
    start_big = 1'b0;
    cyc = 0; reads = 0; writes = 0; twz = 0; seen = 1'b0;
    while (cyc < 6000 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (b_rd_en) begin
        reads++;
        if (b_twiddle_addr == '0) twz++;
      end
      if (b_wr_en) writes++;
      if (b_done) seen = 1'b1;
    end
    check("big_done_seen", 32'(seen), 32'd1);
    check("big_done_cycle", 32'(cyc), 32'd5171);
    check("big_reads", 32'(reads), 32'd5120);
    check("big_writes", 32'(writes), 32'd5120);
    check("big_twiddle_zero", 32'(twz), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
